// File: rtl/ccff_loader_if.sv
// ccff_loader_if: bitstream word handshake between a word source and the chain loader.
interface ccff_loader_if #(parameter int WORD_W = 8);
    logic              bs_valid;
    logic [WORD_W-1:0] bs_data;
    logic              bs_ready;
    modport master(output bs_valid, bs_data, input bs_ready);
    modport slave(input bs_valid, bs_data, output bs_ready);
endinterface

// File: rtl/ccff_loader.sv
// ccff_loader: fetches bitstream words and shifts them MSB-first into a configuration flip-flop chain.
module ccff_loader #(
    parameter int CHAIN_LEN     = 8,
    parameter int WORD_W        = 8,
    parameter int FETCH_TIMEOUT = 255
) (
    input  logic         prog_clk,
    input  logic         pReset_n,
    input  logic         start,
    input  logic         abort,
    ccff_loader_if.slave bs,
    output logic         ccff_head,
    output logic         shift_en,
    input  logic         ccff_tail,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [15:0]  bit_cnt,
    output logic         tail_seen
);
    typedef enum logic [2:0] {IDLE, FETCH, SHIFT, DONE, ERROR} state_t;
    localparam int WCW = $clog2(WORD_W + 1);
    state_t            st;
    logic [WORD_W-1:0] shift_reg;
    logic [WCW-1:0]    wcnt;
    logic [15:0]       wait_cnt;
    logic [16:0]       rem, bit_nxt, wait_nxt;
    assign rem         = 17'(CHAIN_LEN) - 17'(bit_cnt);
    assign bit_nxt     = 17'(bit_cnt) + 17'd1;
    assign wait_nxt    = 17'(wait_cnt) + 17'd1;
    assign bs.bs_ready = st == FETCH;
    assign shift_en    = st == SHIFT;
    assign busy        = bs.bs_ready | shift_en;
    assign ccff_head   = shift_en & shift_reg[WORD_W-1];
    // The cycle carrying abort in SHIFT still clocks the chain, so it is counted too.
    always_ff @(posedge prog_clk) begin
        if (!pReset_n) begin
            st        <= IDLE;
            shift_reg <= '0;
            wcnt      <= '0;
            wait_cnt  <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            tail_seen <= 1'b0;
            bit_cnt   <= '0;
        end else begin
            case (st)
                IDLE, DONE, ERROR: if (start) begin
                    st        <= FETCH;
                    wait_cnt  <= '0;
                    done      <= 1'b0;
                    err       <= 1'b0;
                    tail_seen <= 1'b0;
                    bit_cnt   <= '0;
                end
                FETCH: begin
                    if (abort) st <= IDLE;
                    else if (bs.bs_valid) begin
                        shift_reg <= bs.bs_data;
                        wcnt      <= rem < 17'(WORD_W) ? WCW'(rem) : WCW'(WORD_W);
                        st        <= SHIFT;
                    end else if (wait_nxt == 17'(FETCH_TIMEOUT)) begin
                        st  <= ERROR;
                        err <= 1'b1;
                    end else wait_cnt <= wait_nxt[15:0];
                end
                SHIFT: begin
                    shift_reg <= shift_reg << 1;
                    bit_cnt   <= bit_nxt[15:0];
                    wcnt      <= wcnt - WCW'(1);
                    tail_seen <= tail_seen | ccff_tail;
                    if (abort) st <= IDLE;
                    else if (wcnt == WCW'(1)) begin
                        st       <= bit_nxt == 17'(CHAIN_LEN) ? DONE : FETCH;
                        done     <= bit_nxt == 17'(CHAIN_LEN);
                        wait_cnt <= '0;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ccff_loader.sv
// tb_ccff_loader: scoreboard bench for two loader configurations (8x8 default and 10-bit chain of 4-bit words).
module tb_ccff_loader;
    logic clk = 1'b0, rstn = 1'b0;
    always #5 clk = ~clk;
    logic start0 = 1'b0, abort0 = 1'b0, tail0 = 1'b0, head0, sh0, busy0, done0, err0, ts0;
    logic start1 = 1'b0, abort1 = 1'b0, tail1 = 1'b0, head1, sh1, busy1, done1, err1, ts1;
    logic [15:0] bc0, bc1;
    int n_vec = 0, n_err = 0, sc0 = 0, sc1 = 0;
    bit q0[$], q1[$];
    logic [7:0] src0[$];
    logic [3:0] src1[$];

    ccff_loader_if #(.WORD_W(8)) bs0();
    ccff_loader_if #(.WORD_W(4)) bs1();

    ccff_loader dut0 (
        .prog_clk(clk), .pReset_n(rstn), .start(start0), .abort(abort0), .bs(bs0),
        .ccff_head(head0), .shift_en(sh0), .ccff_tail(tail0), .busy(busy0),
        .done(done0), .err(err0), .bit_cnt(bc0), .tail_seen(ts0));

    ccff_loader #(.CHAIN_LEN(10), .WORD_W(4), .FETCH_TIMEOUT(4)) dut1 (
        .prog_clk(clk), .pReset_n(rstn), .start(start1), .abort(abort1), .bs(bs1),
        .ccff_head(head1), .shift_en(sh1), .ccff_tail(tail1), .busy(busy1),
        .done(done1), .err(err1), .bit_cnt(bc1), .tail_seen(ts1));

    // One clock step: present source words, then score every chain shift against the expected queue.
    task automatic tick();
        bit x0, x1, e;
        bs0.bs_valid = src0.size() > 0;
        bs0.bs_data  = src0.size() > 0 ? src0[0] : 8'h00;
        bs1.bs_valid = src1.size() > 0;
        bs1.bs_data  = src1.size() > 0 ? src1[0] : 4'h0;
        x0 = bs0.bs_valid && bs0.bs_ready;
        x1 = bs1.bs_valid && bs1.bs_ready;
        @(posedge clk);
        #1;
        if (x0) void'(src0.pop_front());
        if (x1) void'(src1.pop_front());
        n_vec++;
        if (sh0) begin
            sc0++;
            if (q0.size() == 0) begin
                n_err++;
                $display("FAIL head0_extra: got shift head=%0b, expected no shift", head0);
            end else begin
                e = q0.pop_front();
                if (head0 !== e) begin
                    n_err++;
                    $display("FAIL head0_bit%0d: got %0b, expected %0b", sc0, head0, e);
                end
            end
        end else if (head0 !== 1'b0) begin
            n_err++;
            $display("FAIL head0_idle: got %0b, expected 0", head0);
        end
        n_vec++;
        if (sh1) begin
            sc1++;
            if (q1.size() == 0) begin
                n_err++;
                $display("FAIL head1_extra: got shift head=%0b, expected no shift", head1);
            end else begin
                e = q1.pop_front();
                if (head1 !== e) begin
                    n_err++;
                    $display("FAIL head1_bit%0d: got %0b, expected %0b", sc1, head1, e);
                end
            end
        end else if (head1 !== 1'b0) begin
            n_err++;
            $display("FAIL head1_idle: got %0b, expected 0", head1);
        end
    endtask

    task automatic push_word0(input logic [7:0] w);
        src0.push_back(w);
        for (int i = 7; i >= 0; i--) q0.push_back(w[i]);
    endtask

    task automatic push_word1(input logic [3:0] w, input int n);
        src1.push_back(w);
        for (int i = 3; i >= 4 - n; i--) q1.push_back(w[i]);
    endtask

    task automatic run0(input int max, output int n);
        n = 0;
        while (!done0 && n < max) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick();
        tick();
        n_vec++;
        if ({bs0.bs_ready, head0, sh0, busy0, done0, err0, bc0, ts0} !== 23'd0) begin
            n_err++;
            $display("FAIL reset0: got %h, expected 0", {bs0.bs_ready, head0, sh0, busy0, done0, err0, bc0, ts0});
        end
        n_vec++;
        if ({bs1.bs_ready, head1, sh1, busy1, done1, err1, bc1, ts1} !== 23'd0) begin
            n_err++;
            $display("FAIL reset1: got %h, expected 0", {bs1.bs_ready, head1, sh1, busy1, done1, err1, bc1, ts1});
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_load_a5();
        int n;
        sc0 = 0;
        push_word0(8'hA5);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        n_vec++;
        if ({busy0, bs0.bs_ready, sh0} !== 3'b110) begin
            n_err++;
            $display("FAIL a5_fetch: got busy/ready/shift=%b, expected 110", {busy0, bs0.bs_ready, sh0});
        end
        run0(40, n);
        n_vec++;
        if (done0 !== 1'b1 || n + 1 != 10) begin
            n_err++;
            $display("FAIL a5_latency: got done=%b at cycle %0d, expected done=1 at cycle 10", done0, n + 1);
        end
        n_vec++;
        if (bc0 !== 16'd8 || sc0 != 8 || q0.size() != 0) begin
            n_err++;
            $display("FAIL a5_count: got bit_cnt=%0d shifts=%0d left=%0d, expected 8 8 0", bc0, sc0, q0.size());
        end
        n_vec++;
        if ({err0, ts0, busy0} !== 3'b000) begin
            n_err++;
            $display("FAIL a5_flags: got err/tail/busy=%b, expected 000", {err0, ts0, busy0});
        end
    endtask

    task automatic test_abort();
        int n;
        abort0 = 1'b1;
        tick();
        abort0 = 1'b0;
        n_vec++;
        if (done0 !== 1'b1) begin
            n_err++;
            $display("FAIL abort_in_done: got done=%b, expected 1", done0);
        end
        sc0 = 0;
        src0.push_back(8'hA5);
        q0.push_back(1'b1); q0.push_back(1'b0); q0.push_back(1'b1);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (3) tick();
        abort0 = 1'b1;
        tick();
        abort0 = 1'b0;
        n_vec++;
        if ({busy0, sh0, done0} !== 3'b000 || bc0 !== 16'd3 || sc0 != 3 || q0.size() != 0) begin
            n_err++;
            $display("FAIL abort_shift: got busy/sh/done=%b bit_cnt=%0d shifts=%0d, expected 000 3 3", {busy0, sh0, done0}, bc0, sc0);
        end
        push_word0(8'h3C);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        n_vec++;
        if (bc0 !== 16'd0 || busy0 !== 1'b1) begin
            n_err++;
            $display("FAIL abort_restart: got bit_cnt=%0d busy=%b, expected 0 1", bc0, busy0);
        end
        run0(40, n);
        n_vec++;
        if (done0 !== 1'b1 || bc0 !== 16'd8) begin
            n_err++;
            $display("FAIL abort_reload: got done=%b bit_cnt=%0d, expected 1 8", done0, bc0);
        end
    endtask

    task automatic test_tail_and_busy_start();
        int n;
        tail0 = 1'b1;
        tick();
        tail0 = 1'b0;
        n_vec++;
        if (ts0 !== 1'b0) begin
            n_err++;
            $display("FAIL tail_outside_shift: got %b, expected 0", ts0);
        end
        push_word0(8'h96);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick();
        tail0 = 1'b1;
        tick();
        tail0 = 1'b0;
        n_vec++;
        if (ts0 !== 1'b1) begin
            n_err++;
            $display("FAIL tail_set: got %b, expected 1", ts0);
        end
        run0(40, n);
        n_vec++;
        if (ts0 !== 1'b1 || done0 !== 1'b1) begin
            n_err++;
            $display("FAIL tail_hold: got tail_seen=%b done=%b, expected 1 1", ts0, done0);
        end
        start0 = 1'b1;
        tick();
        n_vec++;
        if (ts0 !== 1'b0 || bs0.bs_ready !== 1'b1) begin
            n_err++;
            $display("FAIL tail_clear: got tail_seen=%b ready=%b, expected 0 1", ts0, bs0.bs_ready);
        end
        tick();
        start0 = 1'b0;
        push_word0(8'h5A);
        tick();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        n_vec++;
        if (bc0 !== 16'd1 || sh0 !== 1'b1) begin
            n_err++;
            $display("FAIL start_busy: got bit_cnt=%0d shift_en=%b, expected 1 1", bc0, sh0);
        end
        run0(40, n);
        n_vec++;
        if (done0 !== 1'b1 || bc0 !== 16'd8 || q0.size() != 0) begin
            n_err++;
            $display("FAIL start_busy_done: got done=%b bit_cnt=%0d left=%0d, expected 1 8 0", done0, bc0, q0.size());
        end
    endtask

    task automatic load10(input string name);
        int cyc, fb;
        sc1 = 0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        cyc = 1;
        fb = (busy1 && !sh1) ? 1 : 0;
        n_vec++;
        if (done1 !== 1'b0 || busy1 !== 1'b1) begin
            n_err++;
            $display("FAIL %s_start: got done=%b busy=%b, expected 0 1", name, done1, busy1);
        end
        while (!done1 && cyc < 60) begin
            tick();
            cyc++;
            if (busy1 && !sh1) fb++;
        end
        n_vec++;
        if (done1 !== 1'b1 || cyc != 14 || fb != 3) begin
            n_err++;
            $display("FAIL %s_timing: got done=%b cycle=%0d bubbles=%0d, expected 1 14 3", name, done1, cyc, fb);
        end
        n_vec++;
        if (bc1 !== 16'd10 || sc1 != 10 || q1.size() != 0 || src1.size() != 0) begin
            n_err++;
            $display("FAIL %s_count: got bit_cnt=%0d shifts=%0d exp_left=%0d src_left=%0d, expected 10 10 0 0", name, bc1, sc1, q1.size(), src1.size());
        end
    endtask

    task automatic test_bubbles();
        push_word1(4'hF, 4);
        push_word1(4'h0, 4);
        push_word1(4'hC, 2);
        load10("bubbles");
    endtask

    task automatic test_back_to_back();
        push_word1(4'hA, 4);
        push_word1(4'h5, 4);
        push_word1(4'h7, 2);
        load10("b2b");
    endtask

    task automatic test_timeout();
        int s;
        s = sc1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (3) tick();
        n_vec++;
        if (err1 !== 1'b0 || busy1 !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_early: got err=%b busy=%b, expected 0 1", err1, busy1);
        end
        tick();
        n_vec++;
        if ({err1, busy1, bs1.bs_ready, done1} !== 4'b1000 || sc1 != s) begin
            n_err++;
            $display("FAIL timeout_err: got err/busy/ready/done=%b shifts=%0d, expected 1000 %0d", {err1, busy1, bs1.bs_ready, done1}, sc1, s);
        end
        tick();
        n_vec++;
        if (err1 !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_sticky: got %b, expected 1", err1);
        end
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n_vec++;
        if ({err1, busy1, bs1.bs_ready, bc1} !== {3'b011, 16'd0}) begin
            n_err++;
            $display("FAIL timeout_recover: got err/busy/ready=%b bit_cnt=%0d, expected 011 0", {err1, busy1, bs1.bs_ready}, bc1);
        end
        src1.push_back(4'h5);
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        tick();
        n_vec++;
        if ({busy1, done1, sh1} !== 3'b000 || src1.size() != 0 || bc1 !== 16'd0 || sc1 != s) begin
            n_err++;
            $display("FAIL abort_xfer: got busy/done/sh=%b src_left=%0d bit_cnt=%0d shifts=%0d, expected 000 0 0 %0d", {busy1, done1, sh1}, src1.size(), bc1, sc1, s);
        end
    endtask

    task automatic test_reset_midshift();
        push_word0(8'hC3);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick();
        tick();
        void'(q0.pop_back()); void'(q0.pop_back()); void'(q0.pop_back());
        void'(q0.pop_back()); void'(q0.pop_back()); void'(q0.pop_back());
        rstn = 1'b0;
        tick();
        n_vec++;
        if ({bs0.bs_ready, head0, sh0, busy0, done0, err0, bc0, ts0} !== 23'd0) begin
            n_err++;
            $display("FAIL reset_mid: got %h, expected 0", {bs0.bs_ready, head0, sh0, busy0, done0, err0, bc0, ts0});
        end
        rstn = 1'b1;
        abort0 = 1'b1;
        tick();
        tick();
        abort0 = 1'b0;
        n_vec++;
        if ({sh0, busy0, bs0.bs_ready, done0} !== 4'b0000 || q0.size() != 0) begin
            n_err++;
            $display("FAIL reset_after: got sh/busy/ready/done=%b exp_left=%0d, expected 0000 0", {sh0, busy0, bs0.bs_ready, done0}, q0.size());
        end
    endtask

    initial begin
        test_reset();
        test_load_a5();
        test_abort();
        test_tail_and_busy_start();
        test_bubbles();
        test_back_to_back();
        test_timeout();
        test_reset_midshift();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 Parameter CHAIN_LEN, default 8, SHALL set the configuration-chain length in bits (range 1..65535).
REQ-003 Parameter WORD_W, default 8, SHALL set the bitstream word width in bits (range 1..32).
REQ-004 Parameter FETCH_TIMEOUT, default 255, SHALL set the maximum number of cycles to wait for a word (range 1..65535).
REQ-005 prog_clk  in  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-006 pReset_n  in  1  SHALL be the synchronous active-low reset.
REQ-007 start  in  1  SHALL be a single-cycle load request.
REQ-008 abort  in  1  SHALL cancel an in-progress load.
REQ-009 bs_valid  in  1  SHALL mean that bs_data holds a bitstream word.
REQ-010 bs_data  in  WORD_W  SHALL carry the bitstream word; the MSB is shifted first.
REQ-011 bs_ready  out  1  SHALL mean the block accepts a word this cycle; a transfer occurs when bs_valid and bs_ready are both 1.
REQ-012 ccff_head  out  1  SHALL be the serial data driven into the head of the chain.
REQ-013 shift_en  out  1  SHALL be the chain shift enable; the chain captures ccff_head on each prog_clk edge where shift_en=1.
REQ-014 ccff_tail  in  1  SHALL be the chain tail return; it is used only for the tail-activity flag.
REQ-015 busy  out  1  SHALL be 1 in the FETCH and SHIFT states.
REQ-016 done  out  1  SHALL be a sticky flag meaning the load completed.
REQ-017 err  out  1  SHALL be a sticky flag meaning a fetch timeout occurred.
REQ-018 bit_cnt  out  16  SHALL report the number of bits shifted in the current or last load.
REQ-019 tail_seen  out  1  SHALL be a sticky flag meaning ccff_tail was 1 during any shift of the current load.

Function
REQ-020 States SHALL be IDLE, FETCH, SHIFT, DONE and ERROR.
REQ-021 IDLE SHALL go to FETCH on start=1, and SHALL clear done, err, tail_seen and bit_cnt in the same cycle.
REQ-022 In FETCH, bs_ready SHALL be 1 and shift_en SHALL be 0.
REQ-023 On a FETCH transfer, the block SHALL latch bs_data into the shift register, load the word bit counter with min(WORD_W, CHAIN_LEN-bit_cnt), and go to SHIFT.
REQ-024 In SHIFT, ccff_head SHALL equal shift_reg[WORD_W-1], shift_en SHALL be 1, shift_reg SHALL shift left by one each cycle, and bit_cnt SHALL increment by one each cycle.
REQ-025 When the word bit counter reaches 0, SHIFT SHALL go to DONE if bit_cnt==CHAIN_LEN, otherwise to FETCH.
REQ-026 Word bits beyond CHAIN_LEN in the final word SHALL be discarded; they are never shifted into the chain.
REQ-027 Fetching a word SHALL cost exactly one FETCH cycle, during which shift_en=0.
REQ-028 The full-load latency SHALL be ceil(CHAIN_LEN/WORD_W) + CHAIN_LEN cycles from the first FETCH cycle to DONE, given bs_valid=1 throughout.
REQ-029 A wait counter SHALL increment on every FETCH cycle with bs_valid=0 and reset to 0 on entry to FETCH.
REQ-030 When the wait counter reaches FETCH_TIMEOUT, the block SHALL go to ERROR.
REQ-031 In DONE, done SHALL be 1 and the block SHALL go to FETCH on start=1.
REQ-032 In ERROR, err SHALL be 1 and the block SHALL go to FETCH on start=1.
REQ-033 start while busy=1 SHALL be ignored.
REQ-034 abort=1 in FETCH or SHIFT SHALL go to IDLE on the next edge and SHALL keep done=0; bit_cnt retains its partial count.
REQ-035 If abort and a transfer occur in the same cycle, abort SHALL win and the word SHALL be dropped; bs_ready is still 1, so the source counts the word as consumed.
REQ-036 In IDLE, DONE and ERROR, bs_ready=0 and shift_en=0 SHALL hold.
REQ-037 ccff_head SHALL be 0 whenever shift_en=0.
REQ-038 bit_cnt SHALL never exceed CHAIN_LEN.

Reset
REQ-039 While pReset_n=0 at an edge, the block SHALL be in state IDLE with all outputs 0 (bs_ready, ccff_head, shift_en, busy, done, err, bit_cnt, tail_seen) and shift_reg=0.
REQ-040 Reset during SHIFT SHALL drop shift_en on the next edge with no further chain shifts.

Verification
REQ-041 Defaults; start, then bs_data=0xA5 with bs_valid=1 -> shift_en high for 8 cycles, ccff_head sequence 1,0,1,0,0,1,0,1, done=1 on cycle 10 after start, bit_cnt=8.
REQ-042 CHAIN_LEN=10, WORD_W=4; words 0xF, 0x0, 0xC -> 10 shifts, head sequence 1111 0000 11, 3 fetch bubbles, done=1.
REQ-043 FETCH_TIMEOUT=4; start with bs_valid=0 -> err=1 after 4 FETCH cycles, shift_en never 1; a new start then recovers to FETCH.
REQ-044 abort on the 3rd SHIFT cycle -> IDLE next cycle, bit_cnt=3, done=0; a following start reloads from bit_cnt=0.
REQ-045 pReset_n=0 mid-SHIFT -> all outputs 0 on the next edge; start during busy and abort in IDLE have no effect.
REQ-046 ccff_tail driven 1 for one shift cycle -> tail_seen=1, holding until the next start.
